// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and encodings for the pipeline hazard unit and its forwarding selectors.
package pipeline_hazard_unit_pkg;

    localparam int HZ_REG_AW = 5;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Operand bypass selector for one ID source; the youngest producing stage wins.
module fwd_select
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic              src_use_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_rf_le_i,
    input  logic              ex_l_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_rf_le_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_rf_le_i,
    output logic [1:0]        sel_o
);

    // A load in EX has no data yet, so it must not capture the EX bypass path.
    always_comb begin
        sel_o = FWD_RF;
        if (src_use_i && (src_addr_i != '0)) begin
            if (ex_rf_le_i && !ex_l_i && (src_addr_i == ex_rd_i)) begin
                sel_o = FWD_EX;
            end else if (mem_rf_le_i && (src_addr_i == mem_rd_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_rf_le_i && (src_addr_i == wb_rd_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, taken-branch flush and forwarding control for the pipeline registers.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int REG_AW    = HZ_REG_AW,
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rf_le,
    input  logic              ex_l,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rf_le,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_rf_le,
    input  logic              ex_br_taken,
    input  logic              ex_nullify,
    output logic              pc_le,
    output logic              pc_sel,
    output logic              if_id_le,
    output logic              if_id_clr,
    output logic              id_ex_nop,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        hz_state,
    output logic              hazard_err,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int STALL_W = $clog2(MAX_STALL + 2);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_STALL);
    localparam logic [STALL_W-1:0] STALL_SAT   = STALL_W'(MAX_STALL + 1);

    logic lu;
    logic hit_a;
    logic hit_b;

    hz_state_e          state_q, state_d;
    logic [STALL_W-1:0] stall_run_q, stall_run_d;
    logic               err_q, err_d;

    assign hit_a = id_use_a && (id_ra == ex_rd);
    assign hit_b = id_use_b && (id_rb == ex_rd);
    assign lu    = ex_l && ex_rf_le && (ex_rd != '0) && (hit_a || hit_b);

    // The delay slot already sitting in IF/ID proceeds unless the branch nullifies it.
    always_comb begin
        pc_le     = 1'b1;
        pc_sel    = 1'b0;
        if_id_le  = 1'b1;
        if_id_clr = 1'b0;
        id_ex_nop = 1'b0;
        if (ex_br_taken) begin
            pc_sel    = 1'b1;
            if_id_clr = 1'b1;
            id_ex_nop = ex_nullify;
        end else if (lu) begin
            pc_le     = 1'b0;
            if_id_le  = 1'b0;
            id_ex_nop = 1'b1;
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src_addr_i  (id_ra),
        .src_use_i   (id_use_a),
        .ex_rd_i     (ex_rd),
        .ex_rf_le_i  (ex_rf_le),
        .ex_l_i      (ex_l),
        .mem_rd_i    (mem_rd),
        .mem_rf_le_i (mem_rf_le),
        .wb_rd_i     (wb_rd),
        .wb_rf_le_i  (wb_rf_le),
        .sel_o       (fwd_a_sel)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src_addr_i  (id_rb),
        .src_use_i   (id_use_b),
        .ex_rd_i     (ex_rd),
        .ex_rf_le_i  (ex_rf_le),
        .ex_l_i      (ex_l),
        .mem_rd_i    (mem_rd),
        .mem_rf_le_i (mem_rf_le),
        .wb_rd_i     (wb_rd),
        .wb_rf_le_i  (wb_rf_le),
        .sel_o       (fwd_b_sel)
    );

    always_comb begin
        state_d = HZ_RUN;
        case (state_q)
            HZ_RUN: begin
                if (ex_br_taken)  state_d = HZ_FLUSH;
                else if (lu)      state_d = HZ_STALL;
            end
            HZ_STALL: begin
                if (ex_br_taken)  state_d = HZ_FLUSH;
                else if (lu)      state_d = HZ_STALL;
            end
            HZ_FLUSH: begin
                if (ex_br_taken)  state_d = HZ_FLUSH;
                else if (lu)      state_d = HZ_STALL;
            end
            default:              state_d = HZ_RUN;
        endcase
    end

    // Watchdog trips once a stall has lasted MAX_STALL cycles and is still pending.
    always_comb begin
        stall_run_d = '0;
        if (lu) begin
            stall_run_d = (stall_run_q == STALL_SAT) ? stall_run_q : stall_run_q + 1'b1;
        end
        err_d = err_q || (lu && (stall_run_q >= STALL_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HZ_RUN;
            stall_run_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_run_q <= stall_run_d;
            err_q       <= err_d;
        end
    end

    assign hz_state   = state_q;
    assign hazard_err = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (lu && !ex_br_taken && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (ex_br_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Control-side counterpart to the pipeline register chain. The pipeline registers carry state forward; this unit looks back from ID/EX/MEM/WB and drives the enables, clears and bubbles that steer those registers.
- Detects load-use hazards, issues PC/IF-ID freezes and ID/EX bubbles, and flushes the wrong-path fetch on taken branches, preserving the PA-RISC delay slot unless nullified.
- Produces operand forwarding selects and tracks stall/flush state for watchdog and status.

Parameters:
REG_AW, 5, register address width (GR0 hardwired zero)
MAX_STALL, 4, consecutive stall cycles tolerated before hazard_err sets
CNT_W, 16, width of performance counters (optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_ra  in  REG_AW  ID source A address
id_rb  in  REG_AW  ID source B address
id_use_a  in  1  ID instruction reads source A
id_use_b  in  1  ID instruction reads source B
ex_rd  in  REG_AW  EX destination
ex_rf_le  in  1  EX instruction writes RF
ex_l  in  1  EX instruction is a load
mem_rd  in  REG_AW  MEM destination
mem_rf_le  in  1  MEM writes RF
wb_rd  in  REG_AW  WB destination
wb_rf_le  in  1  WB writes RF
ex_br_taken  in  1  branch in EX resolved taken (conditional true or UB)
ex_nullify  in  1  taken branch carries ,n completer
pc_le  out  1  load enable for PC front/back registers
pc_sel  out  1  1 = PC loads branch target
if_id_le  out  1  IF/ID load enable
if_id_clr  out  1  IF/ID clear
id_ex_nop  out  1  force control-signal mux to NOP into ID/EX
fwd_a_sel  out  2  0 RF, 1 EX, 2 MEM, 3 WB
fwd_b_sel  out  2  same encoding for source B
hz_state  out  2  FSM state (0 RUN, 1 STALL, 2 FLUSH)
hazard_err  out  1  sticky watchdog flag
stall_count  out  CNT_W  stall cycles (optional)
flush_count  out  CNT_W  flushes (optional)

Behaviour:
- Interface: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values:
  - hz_state=RUN, hazard_err=0, internal consecutive-stall counter=0, counters=0.
  - Combinational outputs then follow the rules below.
- Load-use hazard, lu (combinational, same cycle): all of the following hold:
  - ex_l & ex_rf_le & ex_rd!=0
  - (id_use_a & id_ra==ex_rd) | (id_use_b & id_rb==ex_rd)
- On lu: pc_le=0, if_id_le=0, id_ex_nop=1, if_id_clr=0.
- Taken branch, ex_br_taken=1: pc_le=1, pc_sel=1, if_id_clr=1.
  - ID holds the delay slot and proceeds: id_ex_nop=0.
  - If ex_nullify, also id_ex_nop=1.
- Priority: taken branch over lu. The branch dominates, lu is ignored that cycle, and if_id_le=1.
- Default (no event): pc_le=1, pc_sel=0, if_id_le=1, if_id_clr=0, id_ex_nop=0.
- Forwarding per source. Address 0 or use=0 gives sel=0. Otherwise the first match wins:
  - EX match (ex_rf_le, not ex_l) -> 1
  - MEM match (mem_rf_le) -> 2
  - WB match (wb_rf_le) -> 3
  - else 0
- FSM, registered at posedge clk:
  - RUN -> FLUSH if ex_br_taken; RUN -> STALL if lu.
  - STALL -> STALL while lu; -> FLUSH if ex_br_taken; else RUN.
  - FLUSH -> FLUSH if ex_br_taken (branch in delay slot legal); -> STALL if lu; else RUN.
- Consecutive-stall counter:
  - Increments each lu cycle (saturates at MAX_STALL+1); clears on any non-lu cycle.
  - When it reaches MAX_STALL and lu is still asserted, hazard_err sets at the next edge. It is sticky until reset.
- Reset mid-stall: next cycle is RUN, counter 0, hazard_err 0.
- Reset has priority over all inputs.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_count increments on each lu cycle not overridden by a branch.
  - flush_count increments on each ex_br_taken cycle.
  - Both are saturating at all-ones and cleared on reset.
- Undefined: ports remain, driven constant 0, no counter flops.

Decomposition:
- Shared package holds:
  - state enum (HZ_RUN=0, HZ_STALL=1, HZ_FLUSH=2)
  - forwarding encodings (FWD_RF, FWD_EX, FWD_MEM, FWD_WB)
  - REG_AW default
- One sub-module: fwd_select, instantiated twice (A/B).
  - Inputs: source address/use plus EX/MEM/WB destination and enable signals.
  - Output: 2-bit select.

Test Plan:
- Load r3 in EX (ex_l=1, ex_rd=3), ID reads id_ra=3 -> pc_le=0, if_id_le=0, id_ex_nop=1 that cycle; hz_state=STALL next cycle; fwd_a_sel=2 once the load is in MEM.
- ex_rd=5 non-load, mem_rd=5, wb_rd=5, all writing, id_rb=5 -> fwd_b_sel=1. Remove EX write -> 2. Remove MEM write -> 3. id_rb=0 -> 0.
- ex_br_taken=1, ex_nullify=0 -> pc_sel=1, if_id_clr=1, id_ex_nop=0; hz_state=FLUSH next. Repeat with ex_nullify=1 -> id_ex_nop=1.
- ex_br_taken=1 in the same cycle as lu -> branch outputs only: if_id_le=1, pc_le=1, id_ex_nop=0.
- Hold lu for 5 cycles with MAX_STALL=4 -> hazard_err=1 after the 5th edge and stays 1. Assert reset -> hazard_err=0, hz_state=RUN.
- With HAZ_PERF_CNT_EN: 3 stall cycles + 2 branches -> stall_count=3, flush_count=2. Without the macro: both read 0.
